// File: rtl/strobe_meter_pkg.sv
// Shared definitions for the strobe interval meter: FSM state encoding and
// width helpers.
package strobe_meter_pkg;

  localparam logic ST_IDLE_ENC    = 1'b0;
  localparam logic ST_MEASURE_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE    = ST_IDLE_ENC,
    ST_MEASURE = ST_MEASURE_ENC
  } state_t;

  // All-ones value for a field of the given width (up to 32 bits).
  function automatic logic [31:0] all_ones(input int width);
    if (width >= 32) return '1;
    else             return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/strobe_interval_meter_sat_tick_counter.sv
// Saturating tick accumulator. next_count/next_sat expose the value the
// counter would take this cycle including the current inc, so the caller can
// capture a closing result without waiting an extra cycle.
module sat_tick_counter
  import strobe_meter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat,
  output logic [WIDTH-1:0] next_count,
  output logic             next_sat
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  logic at_max;

  // Next-value logic: hold at all ones and remember that a tick was lost.
  always_comb begin
    at_max     = (count == ONES);
    next_count = (inc && !at_max) ? count + 1'b1 : count;
    next_sat   = sat | (inc & at_max);
  end

  // Accumulator register; clear wins over counting.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      sat   <= 1'b0;
    end else begin
      count <= next_count;
      sat   <= next_sat;
    end
  end

endmodule

// File: rtl/strobe_interval_meter.sv
// Measures the number of enable-qualified ticks between consecutive strobes
// and presents each result on a one-entry valid/ready output.
module strobe_interval_meter
  import strobe_meter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             strobe,
  input  logic [WIDTH-1:0] expected,
  output logic [WIDTH-1:0] interval,
  output logic             overflow,
  output logic             match,
  output logic             valid,
  input  logic             ready,
  output logic             dropped
);

  state_t           state;
  logic             measuring;
  logic             inc;
  logic [WIDTH-1:0] acc;
  logic             acc_sat;
  logic [WIDTH-1:0] res_count;
  logic             res_sat;

  assign measuring = (state == ST_MEASURE);
  assign inc       = measuring & enable;

  // The arming strobe also clears, but the accumulator is already zero then.
  sat_tick_counter #(.WIDTH(WIDTH)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (strobe),
    .inc        (inc),
    .count      (acc),
    .sat        (acc_sat),
    .next_count (res_count),
    .next_sat   (res_sat)
  );

  // FSM plus output entry: load on a closing strobe unless the old entry is
  // stuck behind backpressure, in which case the new result is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      interval <= '0;
      overflow <= 1'b0;
      match    <= 1'b0;
      valid    <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      dropped <= 1'b0;
      if (valid && ready) valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strobe) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (strobe) begin
            if (!valid || ready) begin
              interval <= res_count;
              overflow <= res_sat;
              match    <= (res_count == expected) && !res_sat;
              valid    <= 1'b1;
            end else begin
              dropped <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strobe_interval_meter.sv
// Directed bench for strobe_interval_meter with an interval-counting model
// compared against the outputs every cycle, plus literal spot checks.
module tb_strobe_interval_meter;

  localparam int WIDTH = 4;
  localparam int MAXV  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             strobe = 1'b0;
  logic             ready = 1'b1;
  logic [WIDTH-1:0] exp_v = 4'd4;
  logic [WIDTH-1:0] interval;
  logic             overflow, match, valid, dropped;

  int tests = 0;
  int fails = 0;

  strobe_interval_meter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .strobe   (strobe),
    .expected (exp_v),
    .interval (interval),
    .overflow (overflow),
    .match    (match),
    .valid    (valid),
    .ready    (ready),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  // Model: count ticks since the last strobe as a plain integer.
  bit armed = 0;
  int cnt = 0;
  int tot;
  bit hs;
  bit chk_on = 0;
  bit mv = 0, mo = 0, mm = 0, md = 0;
  int mi = 0;

  always @(posedge clk) begin
    if (rst) begin
      armed = 0; cnt = 0;
      mv = 0; mi = 0; mo = 0; mm = 0; md = 0;
      chk_on = 1;
    end else begin
      hs = mv && ready;
      md = 0;
      if (!armed) begin
        if (strobe) begin armed = 1; cnt = 0; end
        if (hs) mv = 0;
      end else if (strobe) begin
        tot = cnt + int'(enable);
        cnt = 0;
        if (!mv || ready) begin
          mi = (tot > MAXV) ? MAXV : tot;
          mo = (tot > MAXV);
          mm = (mi == int'(exp_v)) && !mo;
          mv = 1;
        end else begin
          md = 1;
        end
      end else begin
        cnt = cnt + int'(enable);
        if (hs) mv = 0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid",   int'(valid),   int'(mv));
      chk("dropped", int'(dropped), int'(md));
      chk("interval", int'(interval), mi);
      chk("overflow", int'(overflow), int'(mo));
      chk("match",   int'(match),   int'(mm));
    end
  end

  // Apply inputs on the falling edge, return just after the next rising edge.
  task automatic step(input logic e, input logic s, input logic r);
    @(negedge clk);
    enable = e; strobe = s; ready = r;
    @(posedge clk);
    #1;
  endtask

  int dc;

  initial begin
    // 1: reset, then steady enable with a strobe every 4th cycle
    step(1, 0, 1);
    step(1, 1, 1);
    rst = 1'b0;
    chk("reset_valid", int'(valid), 0);
    chk("reset_interval", int'(interval), 0);
    step(1, 1, 1);
    chk("arm_no_valid", int'(valid), 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, (i % 4 == 0), 1);
      if (i == 12) begin
        chk("t1_interval", int'(interval), 4);
        chk("t1_match", int'(match), 1);
        chk("t1_valid", int'(valid), 1);
      end
    end

    // 2: half-duty enable, strobe aligned then shifted onto enable=0
    for (int i = 0; i < 32; i++) begin
      step((i % 2 == 0), (i % 8 == 0), 1);
      if (i == 16) begin
        chk("t2_interval", int'(interval), 4);
        chk("t2_match", int'(match), 1);
      end
    end
    for (int i = 32; i < 64; i++) step((i % 2 == 0), (i % 8 == 1), 1);

    // 3: saturation then recovery
    for (int i = 0; i <= 24; i++) begin
      step(1, (i == 0 || i == 20 || i == 24), 1);
      if (i == 20) begin
        chk("t3_sat_interval", int'(interval), 15);
        chk("t3_sat_overflow", int'(overflow), 1);
        chk("t3_sat_match", int'(match), 0);
      end
      if (i == 24) begin
        chk("t3_rec_interval", int'(interval), 4);
        chk("t3_rec_overflow", int'(overflow), 0);
        chk("t3_rec_match", int'(match), 1);
      end
    end

    // 4: backpressure drops
    step(1, 0, 1);
    step(1, 0, 1);
    dc = 0;
    for (int i = 0; i <= 8; i++) begin
      step(1, (i % 4 == 0), 0);
      if (dropped) dc++;
    end
    chk("t4_drop_count", dc, 2);
    chk("t4_held_interval", int'(interval), 3);
    chk("t4_held_valid", int'(valid), 1);
    step(1, 0, 1);
    chk("t4_drained", int'(valid), 0);

    // 5: transfer coinciding with a closing strobe, then back-to-back strobes
    exp_v = 4'd3;
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 1);
    chk("t5_no_drop", int'(dropped), 0);
    chk("t5_valid", int'(valid), 1);
    chk("t5_interval", int'(interval), 3);
    chk("t5_match", int'(match), 1);
    step(1, 1, 1);
    step(0, 1, 1);
    chk("t5_zero_interval", int'(interval), 0);
    step(1, 1, 1);
    chk("t5_one_interval", int'(interval), 1);

    // 6: reset mid-interval with a held entry
    exp_v = 4'd4;
    step(1, 1, 0);
    step(1, 0, 0);
    rst = 1'b1;
    step(1, 0, 0);
    rst = 1'b0;
    chk("t6_rst_valid", int'(valid), 0);
    chk("t6_rst_interval", int'(interval), 0);
    step(1, 1, 1);
    chk("t6_rearm_no_valid", int'(valid), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    step(1, 1, 1);
    chk("t6_interval", int'(interval), 5);
    chk("t6_valid", int'(valid), 1);
    step(0, 0, 1);
    step(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
